// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dmem_pkg                                                     |
// | Description : Shared types and constants for the downstream memory         |
// |               responder (FSM state encoding, request record, line type).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    // Default line geometry. The responder's parameters default to these;
    // the packed types below describe that default line shape.
    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_BEATS  = 4;

    localparam int BEAT_IDX_W = $clog2(DMEM_BEATS);
    // Latency counter width: supports LATENCY values up to 255.
    localparam int LAT_W      = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        RBURST  = 3'd2,
        WBURST  = 3'd3,
        WCOMMIT = 3'd4
    } state_t;

    typedef logic [DMEM_BEATS-1:0][DMEM_WORD_W-1:0] line_t;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [DMEM_BEATS-1:0] mask;
    } dmem_req_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_line_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_line_ram                                                |
// | Description : DEPTH_LINES x line storage. One asynchronous full-line read  |
// |               port and one synchronous word-masked write port. Storage is  |
// |               never reset.                                                 |
// | Ports       : clk        - clock                                           |
// |               rd_idx_i   - read line index                                 |
// |               rd_line_o  - full line at rd_idx_i                           |
// |               wr_en_i    - write strobe                                    |
// |               wr_idx_i   - write line index                                |
// |               wr_mask_i  - per-word write enable                           |
// |               wr_line_i  - write line data                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_line_ram #(
    parameter int WORD_W      = 32,
    parameter int BEATS       = 4,
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                         clk,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [BEATS-1:0][WORD_W-1:0] rd_line_o,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [BEATS-1:0]             wr_mask_i,
    input  logic [BEATS-1:0][WORD_W-1:0] wr_line_i
);

    logic [BEATS-1:0][WORD_W-1:0] mem_q [DEPTH_LINES];

    assign rd_line_o = mem_q[rd_idx_i];

    // One write lane per word so unmasked words keep their old contents.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (wr_en_i && wr_mask_i[gi]) begin
                mem_q[wr_idx_i][gi] <= wr_line_i[gi];
            end
        end
    end

endmodule : dmem_line_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Downstream memory responder for the cache controller beat    |
// |               interface. Serves one line request at a time: fills return   |
// |               BEATS read beats after LATENCY idle cycles; writebacks take  |
// |               BEATS write beats and commit them under a per-word mask.     |
// | Ports       : clk/rst            - clock, async active-high reset          |
// |               req_*              - request handshake (addr, we, mask)      |
// |               wdata_*            - write beat handshake                    |
// |               rdata_*            - read beat handshake and last marker     |
// |               wr_done            - one-cycle pulse on writeback commit     |
// | Config      : DMEM_WRAP_BURST_EN - reads start at req_addr word and wrap   |
// |               (critical word first); otherwise reads start at word 0.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WORD_W      = DMEM_WORD_W,
    parameter int BEATS       = DMEM_BEATS,
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [BEATS-1:0]  req_mask,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [WORD_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_last,
    output logic              wr_done
);

    localparam int LINE_W = $clog2(DEPTH_LINES);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    state_t                       state_q;
    dmem_req_t                    req_q;
    dmem_req_t                    req_d;
    logic [LAT_W-1:0]             lat_q;
    logic [BEAT_IDX_W-1:0]        beat_q;   // beats transferred so far
    logic [BEAT_IDX_W-1:0]        word_q;   // word index of the current read beat
    logic [BEATS-1:0][WORD_W-1:0] linebuf_q;
    logic                         req_ready_q;
    logic                         wdata_ready_q;
    logic                         rdata_valid_q;
    logic [WORD_W-1:0]            rdata_q;
    logic                         rdata_last_q;
    logic                         wr_done_q;

    logic [LINE_W-1:0]            rd_idx;
    logic [BEATS-1:0][WORD_W-1:0] rd_line;
    logic [BEAT_IDX_W-1:0]        first_word;
    logic [BEAT_IDX_W-1:0]        word_nxt;
    logic [BEAT_IDX_W-1:0]        beat_nxt;
    logic                         unused_addr;

    assign req_d = '{addr: req_addr, we: req_we, mask: req_mask};

    // In IDLE the RAM is addressed from the live request so a LATENCY=0
    // fill can register its first beat on the handshake edge.
    assign rd_idx = (state_q == IDLE) ? req_addr[BEAT_IDX_W +: LINE_W]
                                      : req_q.addr[BEAT_IDX_W +: LINE_W];

`ifdef DMEM_WRAP_BURST_EN
    assign first_word = (state_q == IDLE) ? req_addr[BEAT_IDX_W-1:0]
                                          : req_q.addr[BEAT_IDX_W-1:0];
`else
    assign first_word = '0;
`endif

    // Natural wrap of the narrow index gives the modulo-BEATS word order.
    assign word_nxt = word_q + 1'b1;
    assign beat_nxt = beat_q + 1'b1;

    // Address bits above the line index alias and are deliberately dropped.
    assign unused_addr = ^{req_addr, req_q.addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_q         <= '0;
            lat_q         <= '0;
            beat_q        <= '0;
            word_q        <= '0;
            linebuf_q     <= '0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            rdata_last_q  <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_q       <= req_d;
                        lat_q       <= LAT_W'(LATENCY);
                        beat_q      <= '0;
                        word_q      <= first_word;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            if (req_we) begin
                                state_q       <= WBURST;
                                wdata_ready_q <= 1'b1;
                            end else begin
                                state_q       <= RBURST;
                                rdata_valid_q <= 1'b1;
                                rdata_q       <= rd_line[first_word];
                                rdata_last_q  <= (BEATS == 1);
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    lat_q <= lat_q - 1'b1;
                    // Leaving as the count reaches zero yields exactly
                    // LATENCY cycles spent in WAIT.
                    if (lat_q <= LAT_W'(1)) begin
                        if (req_q.we) begin
                            state_q       <= WBURST;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q       <= RBURST;
                            rdata_valid_q <= 1'b1;
                            rdata_q       <= rd_line[first_word];
                            rdata_last_q  <= (BEATS == 1);
                        end
                    end
                end

                RBURST: begin
                    if (rdata_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q       <= IDLE;
                            rdata_valid_q <= 1'b0;
                            rdata_last_q  <= 1'b0;
                            req_ready_q   <= 1'b1;
                        end else begin
                            beat_q       <= beat_nxt;
                            word_q       <= word_nxt;
                            rdata_q      <= rd_line[word_nxt];
                            rdata_last_q <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end

                WBURST: begin
                    if (wdata_valid && wdata_ready_q) begin
                        linebuf_q[beat_q] <= wdata;
                        if (beat_q == LAST_BEAT) begin
                            state_q       <= WCOMMIT;
                            wdata_ready_q <= 1'b0;
                            wr_done_q     <= 1'b1;
                        end else begin
                            beat_q <= beat_nxt;
                        end
                    end
                end

                WCOMMIT: begin
                    state_q     <= IDLE;
                    wr_done_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dmem_line_ram #(
        .WORD_W      (WORD_W),
        .BEATS       (BEATS),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_ram (
        .clk       (clk),
        .rd_idx_i  (rd_idx),
        .rd_line_o (rd_line),
        .wr_en_i   (state_q == WCOMMIT),
        .wr_idx_i  (req_q.addr[BEAT_IDX_W +: LINE_W]),
        .wr_mask_i (req_q.mask),
        .wr_line_i (linebuf_q)
    );

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign rdata_last  = rdata_last_q;
    assign wr_done     = wr_done_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                            |
// | Description : Directed self-checking bench for dmem_responder. One DUT at  |
// |               LATENCY=3 carries the functional sequence; a second at       |
// |               LATENCY=0 checks zero-latency timing.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_mask;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready, rdata_last, wr_done;
    logic [31:0] rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0;
    logic [3:0]  req_mask0;
    logic        wdata_valid0, wdata_ready0;
    logic [31:0] wdata0;
    logic        rdata_valid0, rdata_ready0, rdata_last0, wr_done0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;

    dmem_responder #(.WORD_W(32), .BEATS(4), .DEPTH_LINES(64), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_mask(req_mask),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .wr_done(wr_done)
    );

    dmem_responder #(.WORD_W(32), .BEATS(4), .DEPTH_LINES(64), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_we(req_we0), .req_mask(req_mask0),
        .wdata_valid(wdata_valid0), .wdata_ready(wdata_ready0), .wdata(wdata0),
        .rdata_valid(rdata_valid0), .rdata_ready(rdata_ready0), .rdata(rdata0),
        .rdata_last(rdata_last0), .wr_done(wr_done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (wr_done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_ready();
        int n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue a request and return after the handshake edge.
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] m);
        wait_req_ready();
        req_valid = 1'b1; req_addr = a; req_we = we; req_mask = m;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n = 0;
        wdata_valid = 1'b1; wdata = d;
        while (!wdata_ready && n < 100) begin tick(); n++; end
        check("wdata_ready_wait", {31'd0, wdata_ready}, 32'd1);
        tick();
        wdata_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [3:0][31:0] w);
        int d0;
        d0 = done_cnt;
        issue(a, 1'b1, m);
        for (int i = 0; i < 4; i++) send_beat(w[i]);
        repeat (3) tick();
        check("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("wr_req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0][31:0] e,
                           input int stall_beat, input int stall_n);
        int n;
        int h;
        rdata_ready = 1'b1;
        issue(a, 1'b0, 4'h0);
        h = cyc_cnt;
        n = 0;
        while (!rdata_valid && n < 100) begin tick(); n++; end
        check("rd_first_beat_latency", 32'(cyc_cnt - h), 32'(LAT));
        for (int i = 0; i < 4; i++) begin
            check("rd_valid", {31'd0, rdata_valid}, 32'd1);
            check("rd_data", rdata, e[i]);
            check("rd_last", {31'd0, rdata_last}, {31'd0, (i == 3)});
            check("rd_req_ready_low", {31'd0, req_ready}, 32'd0);
            if (i == stall_beat) begin
                rdata_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check("stall_valid", {31'd0, rdata_valid}, 32'd1);
                    check("stall_data", rdata, e[i]);
                    check("stall_req_ready", {31'd0, req_ready}, 32'd0);
                end
                rdata_ready = 1'b1;
            end
            tick();
        end
        check("rd_valid_end", {31'd0, rdata_valid}, 32'd0);
        check("rd_req_ready_end", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0][31:0] wv;
        logic [3:0][31:0] ev;
        int d0;

        rst = 1'b1;
        req_valid = 0; req_addr = 0; req_we = 0; req_mask = 0;
        wdata_valid = 0; wdata = 0; rdata_ready = 0;
        req_valid0 = 0; req_addr0 = 0; req_we0 = 0; req_mask0 = 0;
        wdata_valid0 = 0; wdata0 = 0; rdata_ready0 = 0;

        // Reset values
        #2;
        check("rst_req_ready",   {31'd0, req_ready},   32'd0);
        check("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        check("rst_rdata_last",  {31'd0, rdata_last},  32'd0);
        check("rst_wr_done",     {31'd0, wr_done},     32'd0);
        check("rst_rdata",       rdata,                32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("idle_req_ready",  {31'd0, req_ready},  32'd1);
        check("idle_req_ready0", {31'd0, req_ready0}, 32'd1);

        // LATENCY=0: first beat in the cycle right after the handshake
        req_valid0 = 1'b1; req_addr0 = 32'h0; req_we0 = 1'b0; rdata_ready0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        check("lat0_first_beat", {31'd0, rdata_valid0}, 32'd1);
        check("lat0_req_ready",  {31'd0, req_ready0},   32'd0);
        for (int i = 0; i < 4; i++) begin
            check("lat0_valid", {31'd0, rdata_valid0}, 32'd1);
            check("lat0_last",  {31'd0, rdata_last0},  {31'd0, (i == 3)});
            tick();
        end
        check("lat0_valid_end",     {31'd0, rdata_valid0}, 32'd0);
        check("lat0_req_ready_end", {31'd0, req_ready0},   32'd1);

        // Full-mask write then read of line 0x1F0
        wv = {32'hD, 32'hC, 32'hB, 32'hA};
        do_write(32'h1F0, 4'b1111, wv);
        do_read(32'h1F0, wv, -1, 0);

        // Masked write: word 1 untouched
        wv = {32'h4, 32'h3, 32'h2, 32'h1};
        do_write(32'h1F0, 4'b1101, wv);
        ev = {32'h4, 32'h3, 32'hB, 32'h1};
        do_read(32'h1F0, ev, -1, 0);

        // Back-pressure on the second beat for 5 cycles
        do_read(32'h1F0, ev, 1, 5);

        // Address aliasing: 0x2F0 maps to the same line as 0x1F0
        do_read(32'h2F0, ev, -1, 0);

        // Zero mask: beats consumed, wr_done pulses, storage unchanged
        wv = {32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D};
        do_write(32'h1F0, 4'b0000, wv);
        do_read(32'h1F0, ev, -1, 0);

        // Read starting at word 2 of the line
`ifdef DMEM_WRAP_BURST_EN
        ev = {32'hB, 32'h1, 32'h4, 32'h3};
`else
        ev = {32'h4, 32'h3, 32'hB, 32'h1};
`endif
        do_read(32'h1F2, ev, -1, 0);

        // Reset after 2 of 4 write beats: nothing commits
        wv = {32'h44, 32'h33, 32'h22, 32'h11};
        do_write(32'h200, 4'b1111, wv);
        d0 = done_cnt;
        issue(32'h200, 1'b1, 4'b1111);
        send_beat(32'hEE0);
        send_beat(32'hEE1);
        rst = 1'b1;
        #1;
        check("midrst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        check("midrst_req_ready",   {31'd0, req_ready},   32'd0);
        check("midrst_rdata",       rdata,                32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("midrst_no_wr_done", 32'(done_cnt - d0), 32'd0);
        do_read(32'h200, wv, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Downstream memory responder: the far end of the cache controller's downstream beat interface.
- Accepts one cacheline request at a time, either a fill (read) or a writeback (write).
- Reads return 4 data beats after a programmable latency. Writes consume 4 beats and commit them under a per-word mask.
- Synthesizable backing store. Used as the memory model in cache_ctrl benches and as on-chip scratch memory behind the controller.

Parameters:
- WORD_W, 32, width of one beat/word in bits.
- BEATS, 4, words per cacheline (128-bit line); must be a power of 2.
- DEPTH_LINES, 64, number of cachelines stored; must be a power of 2.
- LATENCY, 3, idle cycles between request acceptance and the first read beat or wdata_ready; 0 is legal.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  word address; [1:0] is the word in the line, [31:2] is the line.
- req_we  in  1  1 = writeback, 0 = fill.
- req_mask  in  BEATS  per-word write enable; bit i covers word i; ignored on reads.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted when valid and ready are both high.
- wdata  in  WORD_W  write beat data.
- rdata_valid  out  1  read beat valid.
- rdata_ready  in  1  downstream accepts the read beat.
- rdata  out  WORD_W  read beat data.
- rdata_last  out  1  marks the final beat of a burst.
- wr_done  out  1  one-cycle pulse when a writeback commits.

Behaviour:
- Reset values: req_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, wr_done=0, rdata=0. FSM goes to IDLE; latency and beat counters clear.
- Storage is not reset. Contents survive rst.
- Line index is req_addr[2+log2(DEPTH_LINES)-1:2]. Higher address bits are ignored, so addresses alias modulo DEPTH_LINES.
- FSM states: IDLE, WAIT, RBURST, WBURST, WCOMMIT.
- IDLE: req_ready=1. A handshake latches addr, we and mask, loads the latency counter with LATENCY, and moves to WAIT. If LATENCY=0, it goes straight to RBURST or WBURST.
- WAIT: the counter decrements each cycle. At 0 it moves to RBURST (we=0) or WBURST (we=1). req_ready=0 in every state except IDLE.
- RBURST: rdata_valid=1 and rdata = word[beat]. The beat counter advances only on rdata_valid && rdata_ready; data and valid hold stable under back-pressure. rdata_last=1 on beat BEATS-1. After the last handshake, the FSM returns to IDLE, and req_ready is 1 the next cycle.
- WBURST: wdata_ready=1. Each accepted beat is captured into a line buffer at index beat. After BEATS beats, the FSM moves to WCOMMIT. wdata_valid outside WBURST is ignored; no beat is consumed.
- WCOMMIT (1 cycle): words with mask[i]=1 are written and others are untouched. wr_done pulses, then the FSM returns to IDLE.
- Read-after-write: a fill issued after wr_done returns the committed data. There is no forwarding path, because requests are serialized.
- mask=0 on a write: all beats are still consumed and wr_done still pulses; storage is unchanged.
- Reset mid-burst: the burst is abandoned. A partial write is never committed; outputs return to reset values.
- Throughput: one request is outstanding. A read takes 1 + LATENCY + BEATS cycles minimum.

Optional Feature:
- Macro: DMEM_WRAP_BURST_EN.
- Defined: read beats start at req_addr[1:0] and wrap modulo BEATS (critical word first), e.g. addr word 2 returns words 2,3,0,1. rdata_last is on the 4th beat regardless of start word.
- Undefined: reads always return words 0..BEATS-1 and req_addr[1:0] is ignored.
- Writes are always in order 0..BEATS-1 in both cases.

Decomposition:
- dmem_pkg holds:
  - the state_t enum (IDLE, WAIT, RBURST, WBURST, WCOMMIT);
  - the BEAT_IDX_W and LAT_W constants;
  - line_t, a packed array of BEATS words;
  - dmem_req_t, a struct of addr, we and mask.
- One sub-module, dmem_line_ram: DEPTH_LINES x line_t with one read port and one word-masked write port; no reset on storage.

Test Plan:
1. Write to line 0x1F0>>2 with mask 4'b1111 and beats 0xA,0xB,0xC,0xD, then read 0x1F0 -> rdata 0xA,0xB,0xC,0xD; rdata_last on beat 4; wr_done pulses once.
2. Masked write of beats 0x1..0x4 with mask 4'b1101 over the line from test 1, then read -> 0x1,0xB,0x3,0x4.
3. LATENCY=3: req handshake at cycle t -> first rdata_valid at t+4. With LATENCY=0 -> first beat at t+1.
4. Read with rdata_ready low for 5 cycles on beat 2 -> rdata and rdata_valid held stable; no beat skipped or duplicated; req_ready stays 0 until the final beat completes.
5. Assert rst after 2 of 4 write beats -> no wr_done; a later read of that line returns the pre-write contents.
6. With DMEM_WRAP_BURST_EN, read addr 0x1F2 -> words 2,3,0,1. Without it, the same read -> 0,1,2,3.
